hist_session_ctrl: RTL and testbench

- Session sequencer in front of the `histogramming` core.
- Arbitrates round-robin between two sample requesters (A, B) and feeds accepted samples to the core's write port.
- Stops accumulation after a programmed sample count, waits for the core to settle, then triggers and collects the bin readout stream and reports completion.
- Sits between the top-level I/O wrapper and the core; the core's `reset` is driven by the wrapper as `~rst_n`.

---
 rtl/hist_session_ctrl.sv | 174 +++++++++++++++++
 tb/tb_hist_session_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hist_session_ctrl.sv
// hist_session_ctrl
//   Session sequencer in front of the histogramming core. It round-robins
//   samples from requesters A and B into the core's write port until a
//   programmed sample count is reached. It then waits for the core to report
//   ready for SETTLE consecutive cycles, issues a one-cycle readout trigger,
//   forwards the bin stream, and pulses done at the end of the session.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   start, abort, sample_limit      session control; the limit is latched on start
//   a_valid/a_data/a_ready          requester A sample handshake
//   b_valid/b_data/b_ready          requester B sample handshake
//   core_data_in, core_write_en     registered write port toward the core
//   core_ready                      core can accept a write
//   core_read_req                   one-cycle readout trigger
//   core_data_out/valid_out/last    bin stream coming from the core
//   rd_data, rd_valid, rd_last      bin stream forwarded with one cycle of latency
//   busy, done, err_overrun         session status
//   sample_cnt, bin_cnt             per-session counters
module hist_session_ctrl #(
  parameter int unsigned DATA_W   = 15,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MAX_BINS = 32768,
  parameter int unsigned SETTLE   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  sample_limit,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic [15:0]       core_data_in,
  output logic              core_write_en,
  input  logic              core_ready,
  output logic              core_read_req,
  input  logic [7:0]        core_data_out,
  input  logic              core_valid_out,
  input  logic              core_last_bin,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              busy,
  output logic              done,
  output logic              err_overrun,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [CNT_W-1:0]  bin_cnt
);

  localparam int unsigned      SET_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] LP_MAXB = CNT_W'(MAX_BINS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_SETTLE_W,
    ST_READOUT,
    ST_DONE
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_limit;
  logic [SET_W-1:0]   r_settle;
  logic               r_prio_b;   // 1: B wins the next contested grant

  logic               w_can_grant;
  logic               w_a_win;
  logic               w_b_win;
  logic               w_accept;
  logic [DATA_W-1:0]  w_data;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_bin_nxt;

  // abort drops the readys in the same cycle, so an abort never coincides
  // with an accepted transfer and no write can follow it.
  assign w_can_grant = (r_state == ST_ACCUM) && core_ready &&
                       (sample_cnt < r_limit) && !abort;
  assign w_a_win     = a_valid && (!b_valid || !r_prio_b);
  assign w_b_win     = b_valid && !w_a_win;
  assign a_ready     = w_can_grant && w_a_win;
  assign b_ready     = w_can_grant && w_b_win;
  assign w_accept    = a_ready || b_ready;
  assign w_data      = a_ready ? a_data : b_data;
  assign w_cnt_nxt   = sample_cnt + CNT_W'(1);
  assign w_bin_nxt   = bin_cnt + CNT_W'(1);
  assign busy        = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_limit       <= '0;
      r_settle      <= '0;
      r_prio_b      <= 1'b0;
      core_data_in  <= '0;
      core_write_en <= 1'b0;
      core_read_req <= 1'b0;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
      rd_last       <= 1'b0;
      done          <= 1'b0;
      err_overrun   <= 1'b0;
      sample_cnt    <= '0;
      bin_cnt       <= '0;
    end else begin
      core_write_en <= 1'b0;
      core_read_req <= 1'b0;
      rd_valid      <= 1'b0;
      rd_last       <= 1'b0;
      done          <= 1'b0;
      if (abort) begin
        r_state <= ST_IDLE;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_limit     <= sample_limit;
              r_settle    <= '0;
              sample_cnt  <= '0;
              bin_cnt     <= '0;
              err_overrun <= 1'b0;
              r_state     <= (sample_limit == '0) ? ST_SETTLE_W : ST_ACCUM;
            end
          end
          ST_ACCUM: begin
            if (w_accept) begin
              core_write_en <= 1'b1;
              core_data_in  <= 16'({1'b0, w_data});
              sample_cnt    <= w_cnt_nxt;
              r_prio_b      <= a_ready;
              if (w_cnt_nxt == r_limit) begin
                r_settle <= '0;
                r_state  <= ST_SETTLE_W;
              end
            end
          end
          ST_SETTLE_W: begin
            if (!core_ready) begin
              r_settle <= '0;
            end else if (r_settle == SET_W'(SETTLE - 1)) begin
              core_read_req <= 1'b1;
              r_state       <= ST_READOUT;
            end else begin
              r_settle <= r_settle + SET_W'(1);
            end
          end
          ST_READOUT: begin
            if (core_valid_out) begin
              rd_valid <= 1'b1;
              rd_data  <= core_data_out;
              if (bin_cnt != LP_MAXB) bin_cnt <= w_bin_nxt;
              if (core_last_bin) begin
                rd_last <= 1'b1;
                r_state <= ST_DONE;
              end else if (w_bin_nxt >= LP_MAXB) begin
                err_overrun <= 1'b1;
                r_state     <= ST_DONE;
              end
            end
          end
          ST_DONE: begin
            done    <= 1'b1;
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hist_session_ctrl.sv
module tb_hist_session_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic [15:0] sample_limit = '0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [14:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready;
  logic [15:0] core_data_in;
  logic        core_write_en, core_read_req;
  logic        core_ready = 1'b0;
  logic [7:0]  core_data_out = '0;
  logic        core_valid_out = 1'b0, core_last_bin = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_valid, rd_last, busy, done, err_overrun;
  logic [15:0] sample_cnt, bin_cnt;

  int errors = 0;
  int checks = 0;

  hist_session_ctrl #(.DATA_W(15), .CNT_W(16), .MAX_BINS(4), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .sample_limit(sample_limit),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .core_data_in(core_data_in), .core_write_en(core_write_en),
    .core_ready(core_ready), .core_read_req(core_read_req),
    .core_data_out(core_data_out), .core_valid_out(core_valid_out),
    .core_last_bin(core_last_bin),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .busy(busy), .done(done), .err_overrun(err_overrun),
    .sample_cnt(sample_cnt), .bin_cnt(bin_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] lim);
    start = 1'b1;
    sample_limit = lim;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [65:0] outs;
    tick(); tick();
    outs = {a_ready, b_ready, core_data_in, core_write_en, core_read_req, rd_data,
            rd_valid, rd_last, busy, done, err_overrun, sample_cnt, bin_cnt};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outs: got %h exp 0", outs); end
    rst_n = 1'b1;
    do_start(16'd10);
    a_valid = 1'b1; a_data = 15'h0011; core_ready = 1'b1;
    tick(); tick(); tick();
    checks++;
    if ({core_write_en, sample_cnt} !== {1'b1, 16'd3}) begin
      errors++; $display("FAIL pre_reset_writes: got %h exp %h", {core_write_en, sample_cnt}, {1'b1, 16'd3});
    end
    #1 rst_n = 1'b0;
    #1;
    outs = {a_ready, b_ready, core_data_in, core_write_en, core_read_req, rd_data,
            rd_valid, rd_last, busy, done, err_overrun, sample_cnt, bin_cnt};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL async_reset_outs: got %h exp 0", outs); end
    a_valid = 1'b0; core_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    do_start(16'd2);
    checks++;
    if ({busy, sample_cnt} !== {1'b1, 16'd0}) begin
      errors++; $display("FAIL restart_clean: got %h exp %h", {busy, sample_cnt}, {1'b1, 16'd0});
    end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL restart_abort_busy: got %b exp 0", busy); end
  endtask

  task automatic test_round_robin_readout();
    logic [15:0] exp_d;
    core_ready = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    do_start(16'd4);
    for (int i = 0; i < 4; i++) begin
      a_data = 15'h0100 + 15'(i);
      b_data = 15'h7F00 + 15'(i);
      if (i == 1) begin start = 1'b1; sample_limit = 16'd1; end
      exp_d = (i % 2 == 0) ? {1'b0, a_data} : {1'b0, b_data};
      @(negedge clk);
      checks++;
      if ({a_ready, b_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rr_grant%0d: got %b exp %b", i, {a_ready, b_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      tick();
      start = 1'b0;
      checks++;
      if ({core_write_en, core_data_in, sample_cnt} !== {1'b1, exp_d, 16'(i + 1)}) begin
        errors++; $display("FAIL rr_write%0d: got %h exp %h", i,
                           {core_write_en, core_data_in, sample_cnt}, {1'b1, exp_d, 16'(i + 1)});
      end
    end
    @(negedge clk);
    checks++;
    if ({a_ready, b_ready, busy} !== 3'b001) begin
      errors++; $display("FAIL rr_limit_stop: got %b exp 001", {a_ready, b_ready, busy});
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    checks++;
    if ({core_write_en, core_read_req} !== 2'b00) begin
      errors++; $display("FAIL settle1: got %b exp 00", {core_write_en, core_read_req});
    end
    tick();
    checks++;
    if (core_read_req !== 1'b1) begin errors++; $display("FAIL settle_req: got %b exp 1", core_read_req); end
    core_valid_out = 1'b1; core_data_out = 8'd5;
    tick();
    checks++;
    if ({core_read_req, rd_valid, rd_last, rd_data, bin_cnt} !== {3'b010, 8'd5, 16'd1}) begin
      errors++; $display("FAIL beat5: got %h exp %h", {core_read_req, rd_valid, rd_last, rd_data, bin_cnt}, {3'b010, 8'd5, 16'd1});
    end
    core_data_out = 8'd0;
    tick();
    checks++;
    if ({rd_valid, rd_last, rd_data, bin_cnt} !== {2'b10, 8'd0, 16'd2}) begin
      errors++; $display("FAIL beat0: got %h exp %h", {rd_valid, rd_last, rd_data, bin_cnt}, {2'b10, 8'd0, 16'd2});
    end
    core_data_out = 8'd7; core_last_bin = 1'b1;
    tick();
    core_valid_out = 1'b0; core_last_bin = 1'b0;
    checks++;
    if ({rd_valid, rd_last, rd_data, bin_cnt, done, busy} !== {2'b11, 8'd7, 16'd3, 2'b01}) begin
      errors++; $display("FAIL beat7_last: got %h exp %h", {rd_valid, rd_last, rd_data, bin_cnt, done, busy}, {2'b11, 8'd7, 16'd3, 2'b01});
    end
    tick();
    checks++;
    if ({done, busy, rd_valid} !== 3'b100) begin
      errors++; $display("FAIL done_pulse: got %b exp 100", {done, busy, rd_valid});
    end
    core_valid_out = 1'b1;
    tick();
    core_valid_out = 1'b0;
    checks++;
    if ({done, rd_valid} !== 2'b00) begin
      errors++; $display("FAIL idle_ignore: got %b exp 00", {done, rd_valid});
    end
  endtask

  task automatic test_b_only_toggle();
    logic [3:0] pat = 4'b1101;
    logic       rdy;
    a_valid = 1'b0; b_valid = 1'b1; core_ready = 1'b0;
    do_start(16'd3);
    for (int c = 0; c < 5; c++) begin
      rdy = (c % 2 == 0);
      core_ready = rdy;
      b_data = 15'h0A00 + 15'(c);
      @(negedge clk);
      checks++;
      if ({a_ready, b_ready} !== {1'b0, rdy}) begin
        errors++; $display("FAIL b_grant%0d: got %b exp %b", c, {a_ready, b_ready}, {1'b0, rdy});
      end
      tick();
      checks++;
      if (core_write_en !== rdy || (rdy && core_data_in !== {1'b0, 15'h0A00 + 15'(c)})) begin
        errors++; $display("FAIL b_write%0d: got %b/%h exp %b/%h", c, core_write_en, core_data_in,
                           rdy, {1'b0, 15'h0A00 + 15'(c)});
      end
    end
    checks++;
    if (sample_cnt !== 16'd3) begin errors++; $display("FAIL b_count: got %0d exp 3", sample_cnt); end
    for (int k = 0; k < 4; k++) begin
      core_ready = pat[k];
      @(negedge clk);
      checks++;
      if (b_ready !== 1'b0) begin errors++; $display("FAIL b_settle_ready%0d: got %b exp 0", k, b_ready); end
      tick();
      checks++;
      if (core_read_req !== (k == 3)) begin
        errors++; $display("FAIL settle_restart%0d: got %b exp %b", k, core_read_req, k == 3);
      end
    end
    b_valid = 1'b0;
    core_valid_out = 1'b1; core_last_bin = 1'b1; core_data_out = 8'h09;
    tick();
    core_valid_out = 1'b0; core_last_bin = 1'b0;
    checks++;
    if ({rd_valid, rd_last, rd_data, bin_cnt} !== {2'b11, 8'h09, 16'd1}) begin
      errors++; $display("FAIL b_single_bin: got %h exp %h", {rd_valid, rd_last, rd_data, bin_cnt}, {2'b11, 8'h09, 16'd1});
    end
    tick();
    checks++;
    if ({done, busy} !== 2'b10) begin errors++; $display("FAIL b_done: got %b exp 10", {done, busy}); end
  endtask

  task automatic test_overrun();
    core_ready = 1'b1;
    do_start(16'd0);
    checks++;
    if ({busy, sample_cnt} !== {1'b1, 16'd0}) begin
      errors++; $display("FAIL zero_limit: got %h exp %h", {busy, sample_cnt}, {1'b1, 16'd0});
    end
    tick();
    checks++;
    if (core_read_req !== 1'b0) begin errors++; $display("FAIL zl_settle1: got %b exp 0", core_read_req); end
    tick();
    checks++;
    if (core_read_req !== 1'b1) begin errors++; $display("FAIL zl_req: got %b exp 1", core_read_req); end
    for (int j = 0; j < 4; j++) begin
      core_valid_out = 1'b1; core_data_out = 8'h10 + 8'(j);
      tick();
      checks++;
      if ({rd_valid, rd_last, rd_data, bin_cnt, err_overrun} !== {2'b10, 8'h10 + 8'(j), 16'(j + 1), j == 3}) begin
        errors++; $display("FAIL ovr_beat%0d: got %h exp %h", j, {rd_valid, rd_last, rd_data, bin_cnt, err_overrun},
                           {2'b10, 8'h10 + 8'(j), 16'(j + 1), j == 3});
      end
    end
    tick();
    core_valid_out = 1'b0;
    checks++;
    if ({done, rd_valid, err_overrun, bin_cnt} !== {3'b101, 16'd4}) begin
      errors++; $display("FAIL ovr_done: got %h exp %h", {done, rd_valid, err_overrun, bin_cnt}, {3'b101, 16'd4});
    end
  endtask

  task automatic test_abort();
    a_valid = 1'b1; a_data = 15'h1357; core_ready = 1'b1;
    do_start(16'd5);
    checks++;
    if (err_overrun !== 1'b0) begin errors++; $display("FAIL err_clear: got %b exp 0", err_overrun); end
    tick();
    checks++;
    if ({core_write_en, sample_cnt} !== {1'b1, 16'd1}) begin
      errors++; $display("FAIL abort_prewrite: got %h exp %h", {core_write_en, sample_cnt}, {1'b1, 16'd1});
    end
    abort = 1'b1; a_data = 15'h2468;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b exp 0", a_ready); end
    tick();
    abort = 1'b0; a_valid = 1'b0;
    checks++;
    if ({core_write_en, busy, done, sample_cnt} !== {3'b000, 16'd1}) begin
      errors++; $display("FAIL abort_effect: got %h exp %h", {core_write_en, busy, done, sample_cnt}, {3'b000, 16'd1});
    end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL abort_nodone: got %b exp 0", done); end
    start = 1'b1; abort = 1'b1; sample_limit = 16'd3;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++;
    if ({busy, sample_cnt} !== {1'b0, 16'd1}) begin
      errors++; $display("FAIL start_abort_idle: got %h exp %h", {busy, sample_cnt}, {1'b0, 16'd1});
    end
  endtask

  initial begin
    test_reset();
    test_round_robin_readout();
    test_b_only_toggle();
    test_overrun();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
